rr_bus_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for a shared N:1 data bus mux.

---
 rtl/rr_bus_arbiter_pkg.sv | 29 ++
 rtl/rr_bus_arbiter_if.sv | 33 +++
 rtl/rr_bus_arbiter_rr_pick.sv | 32 +++
 rtl/rr_bus_arbiter.sv | 93 +++++++++
 tb/tb_rr_bus_arbiter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/rr_bus_arbiter_pkg.sv
// arb_pkg: shared types, default parameters and helpers for the round-robin bus arbiter.
// Revision: 1.0
`default_nettype none

package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam int ARB_N        = 4;
  localparam int ARB_DATA_W   = 64;
  localparam int ARB_MAX_HOLD = 8;
  localparam int ONEHOT_MAX   = 64;

  // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [ONEHOT_MAX-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ONEHOT_MAX; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_bus_arbiter_if.sv
// rr_bus_arbiter_if: request/grant handshake and shared data bus between requesters and arbiter.
// Revision: 1.0
`default_nettype none

interface rr_bus_arbiter_if
  import arb_pkg::*;
#(
  parameter int N      = ARB_N,
  parameter int DATA_W = ARB_DATA_W
);
  localparam int SEL_W = $clog2(N);

  logic [N-1:0]        req;
  logic [N-1:0]        done;
  logic [N*DATA_W-1:0] data_in;
  logic [N-1:0]        grant;
  logic [SEL_W-1:0]    sel;
  logic                bus_valid;
  logic [DATA_W-1:0]   bus_out;

  modport master (
    output req, done, data_in,
    input  grant, sel, bus_valid, bus_out
  );

  modport slave (
    input  req, done, data_in,
    output grant, sel, bus_valid, bus_out
  );

endinterface

`default_nettype wire

// File: rtl/rr_bus_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker, scanning last+1, last+2, ... mod N.
// Revision: 1.0
`default_nettype none

module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] win_idx,
  output logic             any_req
);

  logic [SEL_W-1:0] start;
  logic [N-1:0]     rot;
  logic [N-1:0]     first;
  logic [SEL_W-1:0] offset;

  // N is a power of two, so start and win_idx wrap modulo N for free.
  assign start   = last + SEL_W'(1);
  assign rot     = N'({req, req} >> start);
  assign first   = rot & (~rot + N'(1));
  assign offset  = SEL_W'(onehot_to_idx(ONEHOT_MAX'(first)));
  assign win_idx = start + offset;
  assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin owner sequencer with hold timer and N:1 output bus mux tree.
// Revision: 1.0
`default_nettype none

module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic             clk,
  input  logic             reset,
  rr_bus_arbiter_if.slave  bus
);

  localparam int SEL_W = $clog2(N);
  localparam int HC_W  = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]       state;
  logic [SEL_W-1:0] last;
  logic [HC_W-1:0]  hold_cnt;

  logic [SEL_W-1:0] win_idx;
  logic             any_req;
  logic             hold_max;
  logic             rel;
  logic             take;
  logic             drop;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (bus.req),
    .last    (last),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  // In OWNED, last equals the owner, so the same pick serves handover and re-grant.
  assign hold_max = (hold_cnt == HC_W'(MAX_HOLD));
  assign rel      = bus.done[bus.sel] | ~bus.req[bus.sel] | hold_max;
  assign take     = (state == ST_IDLE) ? any_req : (rel & any_req);
  assign drop     = (state == ST_OWNED) & rel & ~any_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      bus.grant     <= '0;
      bus.sel       <= '0;
      bus.bus_valid <= 1'b0;
      hold_cnt      <= '0;
      last          <= SEL_W'(N - 1);
    end else if (take) begin
      state         <= ST_OWNED;
      bus.grant     <= N'(1) << win_idx;
      bus.sel       <= win_idx;
      bus.bus_valid <= 1'b1;
      hold_cnt      <= HC_W'(1);
      last          <= win_idx;
    end else if (drop) begin
      state         <= ST_IDLE;
      bus.grant     <= '0;
      bus.sel       <= '0;
      bus.bus_valid <= 1'b0;
      hold_cnt      <= '0;
    end else if (state == ST_OWNED && !hold_max) begin
      hold_cnt      <= hold_cnt + HC_W'(1);
    end
  end

  // Heap-ordered 2:1 mux tree: node 1 is the root, nodes N..2N-1 are the input words.
  logic [DATA_W-1:0] node [1:2*N-1];

  generate
    for (genvar i = 0; i < N; i++) begin : g_leaf
      assign node[N+i] = bus.data_in[i*DATA_W +: DATA_W];
    end
    for (genvar k = 1; k < N; k++) begin : g_node
      localparam int DEPTH = $clog2(k + 1) - 1;
      assign node[k] = bus.sel[SEL_W-1-DEPTH] ? node[2*k+1] : node[2*k];
    end
  endgenerate

  assign bus.bus_out = bus.bus_valid ? node[1] : '0;

endmodule

`default_nettype wire

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed-vector bench for rr_bus_arbiter (N=4, DATA_W=64, MAX_HOLD=8).
// Revision: 1.0
`default_nettype none

module tb_rr_bus_arbiter;

  localparam int N        = 4;
  localparam int DATA_W   = 64;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  rr_bus_arbiter_if #(.N(N), .DATA_W(DATA_W)) bus_if ();

  rr_bus_arbiter #(
    .N        (N),
    .DATA_W   (DATA_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word_of(input int i);
    return 64'h0123_4567_0000_0000 + 64'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus_if.req  = '0;
    bus_if.done = '0;
    for (int i = 0; i < N; i++) bus_if.data_in[i*DATA_W +: DATA_W] = word_of(i);
    step();
    step();
    reset = 1'b0;
    step();
    vectors++; if (bus_if.grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant: got %b expected 0000", bus_if.grant); end
    vectors++; if (bus_if.sel !== 2'd0) begin miscompares++; $display("FAIL reset_sel: got %0d expected 0", bus_if.sel); end
    vectors++; if (bus_if.bus_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus_if.bus_valid); end
    vectors++; if (bus_if.bus_out !== 64'h0) begin miscompares++; $display("FAIL reset_bus_out: got %h expected 0", bus_if.bus_out); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g [5];
    int           exp_s [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_s = '{0, 1, 2, 3, 0};
    bus_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++; if (bus_if.grant !== exp_g[k]) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus_if.grant, exp_g[k]); end
      vectors++; if (bus_if.sel !== 2'(exp_s[k])) begin miscompares++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", k, bus_if.sel, exp_s[k]); end
      vectors++; if (bus_if.bus_out !== word_of(exp_s[k])) begin miscompares++; $display("FAIL rr_bus_out[%0d]: got %h expected %h", k, bus_if.bus_out, word_of(exp_s[k])); end
      bus_if.done = exp_g[k];
    end
    bus_if.done = '0;
    bus_if.req  = '0;
    step();
    vectors++; if (bus_if.grant !== 4'b0000) begin miscompares++; $display("FAIL rr_release: got %b expected 0000", bus_if.grant); end
  endtask

  task automatic test_bus_data();
    bus_if.data_in[2*DATA_W +: DATA_W] = 64'hDEAD_BEEF;
    bus_if.req = 4'b0100;
    step();
    vectors++; if (bus_if.grant !== 4'b0100) begin miscompares++; $display("FAIL data_grant: got %b expected 0100", bus_if.grant); end
    vectors++; if (bus_if.sel !== 2'd2) begin miscompares++; $display("FAIL data_sel: got %0d expected 2", bus_if.sel); end
    vectors++; if (bus_if.bus_out !== 64'hDEAD_BEEF) begin miscompares++; $display("FAIL data_bus_out: got %h expected 00000000deadbeef", bus_if.bus_out); end
    bus_if.req = 4'b0000;
    step();
    vectors++; if (bus_if.grant !== 4'b0000) begin miscompares++; $display("FAIL data_drop_grant: got %b expected 0000", bus_if.grant); end
    vectors++; if (bus_if.bus_out !== 64'h0) begin miscompares++; $display("FAIL data_drop_bus_out: got %h expected 0", bus_if.bus_out); end
    vectors++; if (bus_if.bus_valid !== 1'b0) begin miscompares++; $display("FAIL data_drop_valid: got %b expected 0", bus_if.bus_valid); end
    bus_if.data_in[2*DATA_W +: DATA_W] = word_of(2);
  endtask

  task automatic test_hold_timer();
    // Last owner was 2, so scan order is 3,0,1: requester 0 wins; done[1] from a non-owner is ignored.
    bus_if.req  = 4'b0011;
    bus_if.done = 4'b0010;
    for (int k = 0; k < MAX_HOLD; k++) begin
      step();
      if (k == 3) bus_if.done = '0;
      vectors++; if (bus_if.grant !== 4'b0001) begin miscompares++; $display("FAIL hold_grant[%0d]: got %b expected 0001", k, bus_if.grant); end
    end
    step();
    vectors++; if (bus_if.grant !== 4'b0010) begin miscompares++; $display("FAIL hold_handover: got %b expected 0010", bus_if.grant); end
    vectors++; if (dut.hold_cnt !== 4'd1) begin miscompares++; $display("FAIL hold_cnt_new_owner: got %0d expected 1", dut.hold_cnt); end
  endtask

  task automatic test_timer_regrant();
    bus_if.req = 4'b0010;
    for (int k = 0; k < MAX_HOLD - 1; k++) begin
      step();
      vectors++; if (bus_if.grant !== 4'b0010) begin miscompares++; $display("FAIL regrant_hold[%0d]: got %b expected 0010", k, bus_if.grant); end
      vectors++; if (dut.hold_cnt !== 4'(k + 2)) begin miscompares++; $display("FAIL regrant_cnt[%0d]: got %0d expected %0d", k, dut.hold_cnt, k + 2); end
    end
    step();
    vectors++; if (bus_if.grant !== 4'b0010) begin miscompares++; $display("FAIL regrant_grant: got %b expected 0010", bus_if.grant); end
    vectors++; if (bus_if.bus_valid !== 1'b1) begin miscompares++; $display("FAIL regrant_bubble: got %b expected 1", bus_if.bus_valid); end
    vectors++; if (dut.hold_cnt !== 4'd1) begin miscompares++; $display("FAIL regrant_cnt_restart: got %0d expected 1", dut.hold_cnt); end
  endtask

  task automatic test_async_reset();
    bus_if.req = 4'b1000;
    step();
    vectors++; if (bus_if.grant !== 4'b1000) begin miscompares++; $display("FAIL areset_owner3: got %b expected 1000", bus_if.grant); end
    #3;
    reset = 1'b1;
    #1;
    vectors++; if (bus_if.grant !== 4'b0000) begin miscompares++; $display("FAIL areset_grant: got %b expected 0000", bus_if.grant); end
    vectors++; if (bus_if.bus_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid: got %b expected 0", bus_if.bus_valid); end
    vectors++; if (bus_if.bus_out !== 64'h0) begin miscompares++; $display("FAIL areset_bus_out: got %h expected 0", bus_if.bus_out); end
    bus_if.req = 4'b1001;
    step();
    reset = 1'b0;
    step();
    vectors++; if (bus_if.grant !== 4'b0001) begin miscompares++; $display("FAIL areset_restart: got %b expected 0001", bus_if.grant); end
    vectors++; if (bus_if.sel !== 2'd0) begin miscompares++; $display("FAIL areset_restart_sel: got %0d expected 0", bus_if.sel); end
    bus_if.done = 4'b0001;
    step();
    bus_if.done = '0;
    vectors++; if (bus_if.grant !== 4'b1000) begin miscompares++; $display("FAIL areset_next: got %b expected 1000", bus_if.grant); end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    bus_if.req     = '0;
    bus_if.done    = '0;
    bus_if.data_in = '0;
    test_reset();
    test_round_robin();
    test_bus_data();
    test_hold_timer();
    test_timer_regrant();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
